// File: rtl/alu_exec_sequencer_if.sv
// Bundle of all handshake and data buses around the ALU execute sequencer.
// The sequencer takes the master side; fetch, register file, memory and ALU sit on the slave side.
interface alu_exec_sequencer_if;
    logic        ir_valid;
    logic [15:0] ir_data;
    logic        ir_ready;

    logic [3:0]  rf_sel_s;
    logic [3:0]  rf_sel_d;
    logic [15:0] rf_rdata_s;
    logic [15:0] rf_rdata_d;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    logic [3:0]  alu_opcode;
    logic [2:0]  alu_subop;
    logic        alu_bw;
    logic [15:0] alu_src;
    logic [15:0] alu_dst;
    logic        alu_start;
    logic        alu_done;
    logic [15:0] alu_res;
    logic [3:0]  alu_flags;

    logic [3:0]  sr_flags;
    logic        jmp_valid;
    logic [15:0] jmp_offset;
    logic        busy;
    logic        illegal;

    modport master (
        input  ir_valid, ir_data,
        output ir_ready,
        output rf_sel_s, rf_sel_d,
        input  rf_rdata_s, rf_rdata_d,
        output rf_we, rf_waddr, rf_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata,
        output alu_opcode, alu_subop, alu_bw, alu_src, alu_dst, alu_start,
        input  alu_done, alu_res, alu_flags,
        output sr_flags, jmp_valid, jmp_offset, busy, illegal
    );

    modport slave (
        output ir_valid, ir_data,
        input  ir_ready,
        input  rf_sel_s, rf_sel_d,
        output rf_rdata_s, rf_rdata_d,
        input  rf_we, rf_waddr, rf_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata,
        input  alu_opcode, alu_subop, alu_bw, alu_src, alu_dst, alu_start,
        output alu_done, alu_res, alu_flags,
        input  sr_flags, jmp_valid, jmp_offset, busy, illegal
    );
endinterface

// File: rtl/alu_exec_sequencer.sv
// Multi-cycle execute sequencer for an MSP430-style 16-bit ALU: decodes Format I/II and jumps,
// resolves operands through memory, issues the ALU and writes back result and flags.
module alu_exec_sequencer #(
    parameter logic [3:0] RST_SR = 4'b0000
) (
    input logic MCLK,
    input logic RST,
    alu_exec_sequencer_if.master bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DECODE,
        S_EXT_S,
        S_MEM_S,
        S_EXT_D,
        S_MEM_D,
        S_ISSUE,
        S_WAIT_ALU,
        S_WB
    } state_t;

    state_t      r_state;
    logic [15:0] r_ir;
    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [15:0] r_addr;
    logic [15:0] r_res;
    logic [3:0]  r_resFlags;
    logic [3:0]  r_sr;

    state_t      w_stateNext;
    logic [15:0] w_irNext;
    logic [15:0] w_srcNext;
    logic [15:0] w_dstNext;
    logic [15:0] w_addrNext;
    logic [15:0] w_resNext;
    logic [3:0]  w_resFlagsNext;
    logic [3:0]  w_srNext;

    logic        w_irReady;
    logic        w_rfWe;
    logic [3:0]  w_rfWaddr;
    logic [15:0] w_rfWdata;
    logic        w_memReq;
    logic        w_memWe;
    logic [15:0] w_memAddr;
    logic [15:0] w_memWdata;
    logic        w_aluStart;
    logic        w_jmpValid;
    logic        w_illegal;
    logic        w_srcDone;
    logic [15:0] w_srcVal;
    logic [15:0] w_rdVal;

    logic [3:0]  w_opcode;
    logic        w_isFmt1;
    logic        w_isFmt2;
    logic        w_isJump;
    logic        w_isIllegal;
    logic        w_bw;
    logic [1:0]  w_as;
    logic        w_ad;
    logic [3:0]  w_rs;
    logic [3:0]  w_rd;
    logic        w_isImm;
    logic        w_jumpTaken;
    logic        w_noFlags;
    logic        w_noWrite;
    logic        w_dstMem;
    logic [15:0] w_incr;

    function automatic logic [15:0] maskOp(input logic [15:0] v, input logic bw);
        return bw ? {8'h00, v[7:0]} : v;
    endfunction

    assign w_opcode    = r_ir[15:12];
    assign w_isFmt2    = (w_opcode == 4'b0001);
    assign w_isJump    = (w_opcode[3:1] == 3'b001);
    assign w_isFmt1    = (w_opcode[3:2] != 2'b00);
    assign w_isIllegal = (w_opcode == 4'b0000) || (w_isFmt2 && r_ir[9]);
    assign w_bw        = r_ir[6];
    assign w_as        = r_ir[5:4];
    // Bit 7 is the low sub-opcode bit in Format II, so Ad only exists for Format I
    assign w_ad        = w_isFmt1 & r_ir[7];
    assign w_rs        = w_isFmt2 ? r_ir[3:0] : r_ir[11:8];
    assign w_rd        = r_ir[3:0];
    assign w_isImm     = (w_as == 2'b11) && (w_rs == 4'd0);
    assign w_noFlags   = (w_opcode == 4'b0100) || (w_isFmt2 && (r_ir[9:7] == 3'b001));
    assign w_noWrite   = (w_isFmt1 && ((w_opcode == 4'b1001) || (w_opcode == 4'b1011)))
                       || (w_isFmt2 && w_isImm);
    assign w_dstMem    = w_isFmt1 ? w_ad : ((w_as != 2'b00) && !w_isImm);
    assign w_incr      = w_bw ? 16'd1 : 16'd2;

    always_comb begin
        w_jumpTaken = 1'b0;
        case (r_ir[12:10])
            3'b000:  w_jumpTaken = ~r_sr[1];
            3'b001:  w_jumpTaken = r_sr[1];
            3'b010:  w_jumpTaken = ~r_sr[0];
            3'b011:  w_jumpTaken = r_sr[0];
            3'b100:  w_jumpTaken = r_sr[2];
            3'b101:  w_jumpTaken = ~(r_sr[2] ^ r_sr[3]);
            3'b110:  w_jumpTaken = r_sr[2] ^ r_sr[3];
            default: w_jumpTaken = 1'b1;
        endcase
    end

    always_comb begin
        w_stateNext    = r_state;
        w_irNext       = r_ir;
        w_srcNext      = r_src;
        w_dstNext      = r_dst;
        w_addrNext     = r_addr;
        w_resNext      = r_res;
        w_resFlagsNext = r_resFlags;
        w_srNext       = r_sr;
        w_irReady      = 1'b0;
        w_rfWe         = 1'b0;
        w_rfWaddr      = 4'd0;
        w_rfWdata      = 16'd0;
        w_memReq       = 1'b0;
        w_memWe        = 1'b0;
        w_memAddr      = 16'd0;
        w_memWdata     = 16'd0;
        w_aluStart     = 1'b0;
        w_jmpValid     = 1'b0;
        w_illegal      = 1'b0;
        w_srcDone      = 1'b0;
        w_srcVal       = 16'd0;
        w_rdVal        = bus.rf_rdata_d;

        case (r_state)
            S_IDLE: begin
                w_irReady = 1'b1;
                if (bus.ir_valid) begin
                    w_irNext    = bus.ir_data;
                    w_stateNext = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_isIllegal) begin
                    w_illegal   = 1'b1;
                    w_stateNext = S_IDLE;
                end else if (w_isJump) begin
                    w_jmpValid  = w_jumpTaken;
                    w_stateNext = S_IDLE;
                end else begin
                    case (w_as)
                        2'b00: begin
                            w_srcDone = 1'b1;
                            w_srcVal  = bus.rf_rdata_s;
                        end
                        2'b01: w_stateNext = S_EXT_S;
                        2'b10: begin
                            w_addrNext  = bus.rf_rdata_s;
                            w_stateNext = S_MEM_S;
                        end
                        default: begin
                            if (w_isImm) begin
                                w_stateNext = S_EXT_S;
                            end else begin
                                w_addrNext  = bus.rf_rdata_s;
                                w_stateNext = S_MEM_S;
                            end
                        end
                    endcase
                end
            end
            S_EXT_S: begin
                w_irReady = 1'b1;
                if (bus.ir_valid) begin
                    if (w_isImm) begin
                        w_srcDone = 1'b1;
                        w_srcVal  = bus.ir_data;
                    end else begin
                        w_addrNext  = bus.ir_data + bus.rf_rdata_s;
                        w_stateNext = S_MEM_S;
                    end
                end
            end
            S_MEM_S: begin
                w_memReq  = 1'b1;
                w_memAddr = r_addr;
                if (bus.mem_ack) begin
                    w_srcDone = 1'b1;
                    w_srcVal  = bus.mem_rdata;
                    if (w_as == 2'b11) begin
                        w_rfWe    = 1'b1;
                        w_rfWaddr = w_rs;
                        w_rfWdata = r_addr + w_incr;
                    end
                end
            end
            S_EXT_D: begin
                w_irReady = 1'b1;
                if (bus.ir_valid) begin
                    w_addrNext  = bus.ir_data + bus.rf_rdata_d;
                    w_stateNext = S_MEM_D;
                end
            end
            S_MEM_D: begin
                w_memReq  = 1'b1;
                w_memAddr = r_addr;
                if (bus.mem_ack) begin
                    w_dstNext   = maskOp(bus.mem_rdata, w_bw);
                    w_stateNext = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_aluStart  = 1'b1;
                w_stateNext = S_WAIT_ALU;
            end
            S_WAIT_ALU: begin
                if (bus.alu_done) begin
                    w_resNext      = bus.alu_res;
                    w_resFlagsNext = bus.alu_flags;
                    w_stateNext    = S_WB;
                end
            end
            S_WB: begin
                if (!w_noFlags) begin
                    w_srNext = r_resFlags;
                end
                if (w_noWrite) begin
                    w_stateNext = S_IDLE;
                end else if (w_dstMem) begin
                    w_memReq   = 1'b1;
                    w_memWe    = 1'b1;
                    w_memAddr  = r_addr;
                    w_memWdata = r_res;
                    if (bus.mem_ack) begin
                        w_stateNext = S_IDLE;
                    end
                end else begin
                    w_rfWe      = 1'b1;
                    w_rfWaddr   = w_rd;
                    w_rfWdata   = r_res;
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase

        // A post-increment landing on the destination register must be seen by the register operand
        if (w_rfWe && (w_rfWaddr == w_rd)) begin
            w_rdVal = w_rfWdata;
        end

        if (w_srcDone) begin
            w_srcNext = maskOp(w_srcVal, w_bw);
            if (w_isFmt2) begin
                w_dstNext   = maskOp(w_srcVal, w_bw);
                w_stateNext = S_ISSUE;
            end else if (w_ad) begin
                w_stateNext = S_EXT_D;
            end else begin
                w_dstNext   = maskOp(w_rdVal, w_bw);
                w_stateNext = S_ISSUE;
            end
        end
    end

    always_ff @(posedge MCLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_ir       <= 16'd0;
            r_src      <= 16'd0;
            r_dst      <= 16'd0;
            r_addr     <= 16'd0;
            r_res      <= 16'd0;
            r_resFlags <= 4'd0;
            r_sr       <= RST_SR;
        end else begin
            r_state    <= w_stateNext;
            r_ir       <= w_irNext;
            r_src      <= w_srcNext;
            r_dst      <= w_dstNext;
            r_addr     <= w_addrNext;
            r_res      <= w_resNext;
            r_resFlags <= w_resFlagsNext;
            r_sr       <= w_srNext;
        end
    end

    // Strobes are cut by RST in the same cycle so an abort never lets a write or request slip out
    assign bus.ir_ready   = w_irReady;
    assign bus.rf_sel_s   = w_rs;
    assign bus.rf_sel_d   = w_rd;
    assign bus.rf_we      = w_rfWe & ~RST;
    assign bus.rf_waddr   = w_rfWaddr;
    assign bus.rf_wdata   = w_rfWdata;
    assign bus.mem_req    = w_memReq & ~RST;
    assign bus.mem_we     = w_memWe & ~RST;
    assign bus.mem_addr   = w_memAddr;
    assign bus.mem_wdata  = w_memWdata;
    assign bus.alu_opcode = w_opcode;
    assign bus.alu_subop  = r_ir[9:7];
    assign bus.alu_bw     = w_bw;
    assign bus.alu_src    = r_src;
    assign bus.alu_dst    = r_dst;
    assign bus.alu_start  = w_aluStart & ~RST;
    assign bus.sr_flags   = r_sr;
    assign bus.jmp_valid  = w_jmpValid & ~RST;
    assign bus.jmp_offset = {{5{r_ir[9]}}, r_ir[9:0], 1'b0};
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.illegal    = w_illegal & ~RST;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Directed bench for alu_exec_sequencer with behavioural register file, memory and ALU models.
// Expected values are hand-computed per instruction vector.
module tb_alu_exec_sequencer;

    localparam logic [3:0] TB_RST_SR = 4'b0100;

    logic MCLK = 1'b0;
    logic RST  = 1'b1;
    logic holdAck = 1'b0;
    logic memAck;

    logic [15:0] regFile [16];
    logic [15:0] mem [1024];

    int checkCount = 0;
    int errorCount = 0;
    int rfWeCount = 0;
    int jmpCount = 0;
    int illegalCount = 0;
    int wordCount = 0;
    int busyCount = 0;
    int memWrCount = 0;
    logic [3:0]  lastRfWaddr = 4'd0;
    logic [15:0] lastRfWdata = 16'd0;
    logic [15:0] lastJmpOffset = 16'd0;
    logic [15:0] lastMemRaddr = 16'd0;
    logic [15:0] lastMemWaddr = 16'd0;
    logic [15:0] lastMemWdata = 16'd0;
    logic [15:0] capSrc = 16'd0;
    logic [15:0] capDst = 16'd0;

    int rfBase, jmpBase, illBase, wordBase, busyBase, memWrBase;

    alu_exec_sequencer_if ifc ();

    alu_exec_sequencer #(.RST_SR(TB_RST_SR)) dut (
        .MCLK(MCLK),
        .RST (RST),
        .bus (ifc.master)
    );

    always #5 MCLK = ~MCLK;

    assign ifc.rf_rdata_s = regFile[ifc.rf_sel_s];
    assign ifc.rf_rdata_d = regFile[ifc.rf_sel_d];
    assign ifc.mem_ack    = memAck;
    assign ifc.mem_rdata  = memAck ? mem[ifc.mem_addr[9:0]] : 16'h0000;

    always @(posedge MCLK) begin
        if (RST) begin
            for (int i = 0; i < 16; i++) regFile[i] <= 16'h0000;
            regFile[4] <= 16'h0003;
            regFile[5] <= 16'h0004;
            regFile[7] <= 16'h0200;
            regFile[8] <= 16'h1111;
            regFile[9] <= 16'hFFFF;
        end else if (ifc.rf_we) begin
            regFile[ifc.rf_waddr] <= ifc.rf_wdata;
        end
    end

    // Memory answers one cycle after a request unless holdAck stalls it
    always @(posedge MCLK) begin
        if (RST) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[10'h200] <= 16'h01FF;
            mem[10'h001] <= 16'h0010;
            memAck <= 1'b0;
        end else begin
            memAck <= ifc.mem_req && !memAck && !holdAck;
            if (memAck && ifc.mem_we) mem[ifc.mem_addr[9:0]] <= ifc.mem_wdata;
        end
    end

    always @(posedge MCLK) begin
        ifc.alu_done <= ifc.alu_start && !RST;
    end

    always @(negedge MCLK) begin
        if (ifc.rf_we) begin
            rfWeCount++;
            lastRfWaddr = ifc.rf_waddr;
            lastRfWdata = ifc.rf_wdata;
        end
        if (ifc.jmp_valid) begin
            jmpCount++;
            lastJmpOffset = ifc.jmp_offset;
        end
        if (ifc.illegal) illegalCount++;
        if (ifc.ir_valid && ifc.ir_ready && !RST) wordCount++;
        if (ifc.busy) busyCount++;
        if (ifc.mem_ack && ifc.mem_req && !ifc.mem_we) lastMemRaddr = ifc.mem_addr;
        if (ifc.mem_ack && ifc.mem_req && ifc.mem_we) begin
            memWrCount++;
            lastMemWaddr = ifc.mem_addr;
            lastMemWdata = ifc.mem_wdata;
        end
        if (ifc.alu_start) begin
            capSrc = ifc.alu_src;
            capDst = ifc.alu_dst;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] word);
        int n = 0;
        ifc.ir_valid = 1'b1;
        ifc.ir_data  = word;
        while (!ifc.ir_ready && n < 50) begin
            @(negedge MCLK);
            n++;
        end
        if (n >= 50) checkOutput("readyTimeout", {31'd0, ifc.ir_ready}, 32'd1);
        @(posedge MCLK);
        #1;
        ifc.ir_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        @(negedge MCLK);
        while (ifc.busy && n < 60) begin
            @(negedge MCLK);
            n++;
        end
        if (n >= 60) checkOutput("idleTimeout", {31'd0, ifc.busy}, 32'd0);
    endtask

    task automatic snapshot();
        rfBase    = rfWeCount;
        jmpBase   = jmpCount;
        illBase   = illegalCount;
        wordBase  = wordCount;
        busyBase  = busyCount;
        memWrBase = memWrCount;
    endtask

    initial begin
        ifc.ir_valid  = 1'b0;
        ifc.ir_data   = 16'h0000;
        ifc.alu_res   = 16'h0000;
        ifc.alu_flags = 4'b0000;
        RST = 1'b1;
        repeat (3) @(posedge MCLK);
        #1;
        checkOutput("rstBusy", {31'd0, ifc.busy}, 32'd0);
        checkOutput("rstMemReq", {31'd0, ifc.mem_req}, 32'd0);
        checkOutput("rstSr", {28'd0, ifc.sr_flags}, {28'd0, TB_RST_SR});
        checkOutput("rstIrReady", {31'd0, ifc.ir_ready}, 32'd1);
        checkOutput("rstAluSrc", {16'd0, ifc.alu_src}, 32'h0);
        RST = 1'b0;
        @(negedge MCLK);

        $display("[TB] ADD R4,R5");
        ifc.alu_res = 16'h0007; ifc.alu_flags = 4'b0000;
        snapshot();
        applyStimulus(16'h5405);
        waitIdle();
        checkOutput("addSrc", {16'd0, capSrc}, 32'h0003);
        checkOutput("addDst", {16'd0, capDst}, 32'h0004);
        checkOutput("addWaddr", {28'd0, lastRfWaddr}, 32'd5);
        checkOutput("addWdata", {16'd0, lastRfWdata}, 32'h0007);
        checkOutput("addSr", {28'd0, ifc.sr_flags}, 32'h0);
        checkOutput("addBusyCycles", busyCount - busyBase, 32'd4);

        $display("[TB] MOV #0x1234,R6");
        ifc.alu_res = 16'h1234; ifc.alu_flags = 4'b1111;
        snapshot();
        applyStimulus(16'h4036);
        applyStimulus(16'h1234);
        waitIdle();
        checkOutput("movWords", wordCount - wordBase, 32'd2);
        checkOutput("movSrc", {16'd0, capSrc}, 32'h1234);
        checkOutput("movR6", {16'd0, regFile[6]}, 32'h1234);
        checkOutput("movWaddr", {28'd0, lastRfWaddr}, 32'd6);
        checkOutput("movSrKept", {28'd0, ifc.sr_flags}, 32'h0);

        $display("[TB] CMP.B @R7+,R8");
        ifc.alu_res = 16'h00EE; ifc.alu_flags = 4'b0010;
        snapshot();
        applyStimulus(16'h9778);
        waitIdle();
        checkOutput("cmpRdAddr", {16'd0, lastMemRaddr}, 32'h0200);
        checkOutput("cmpSrc", {16'd0, capSrc}, 32'h00FF);
        checkOutput("cmpDst", {16'd0, capDst}, 32'h0011);
        checkOutput("cmpR7Inc", {16'd0, regFile[7]}, 32'h0201);
        checkOutput("cmpRfWrites", rfWeCount - rfBase, 32'd1);
        checkOutput("cmpR8Kept", {16'd0, regFile[8]}, 32'h1111);
        checkOutput("cmpSr", {28'd0, ifc.sr_flags}, 32'h2);

        $display("[TB] JEQ taken");
        snapshot();
        applyStimulus(16'h2401);
        waitIdle();
        checkOutput("jeqPulse", jmpCount - jmpBase, 32'd1);
        checkOutput("jeqOffset", {16'd0, lastJmpOffset}, 32'h0002);

        $display("[TB] ADD R4,2(R9) wrap");
        ifc.alu_res = 16'h0013; ifc.alu_flags = 4'b0001;
        snapshot();
        applyStimulus(16'h5489);
        applyStimulus(16'h0002);
        waitIdle();
        checkOutput("wrapRdAddr", {16'd0, lastMemRaddr}, 32'h0001);
        checkOutput("wrapDst", {16'd0, capDst}, 32'h0010);
        checkOutput("wrapWrAddr", {16'd0, lastMemWaddr}, 32'h0001);
        checkOutput("wrapWrData", {16'd0, lastMemWdata}, 32'h0013);
        checkOutput("wrapMem", {16'd0, mem[1]}, 32'h0013);
        checkOutput("wrapRfWrites", rfWeCount - rfBase, 32'd0);
        checkOutput("wrapSr", {28'd0, ifc.sr_flags}, 32'h1);

        $display("[TB] JEQ not taken, JMP backward");
        snapshot();
        applyStimulus(16'h2401);
        waitIdle();
        checkOutput("jeqNoPulse", jmpCount - jmpBase, 32'd0);
        applyStimulus(16'h3FFF);
        waitIdle();
        checkOutput("jmpPulse", jmpCount - jmpBase, 32'd1);
        checkOutput("jmpOffset", {16'd0, lastJmpOffset}, 32'hFFFE);

        $display("[TB] SWPB R4");
        ifc.alu_res = 16'h0300; ifc.alu_flags = 4'b1111;
        snapshot();
        applyStimulus(16'h1084);
        waitIdle();
        checkOutput("swpbSrc", {16'd0, capSrc}, 32'h0003);
        checkOutput("swpbDst", {16'd0, capDst}, 32'h0003);
        checkOutput("swpbR4", {16'd0, regFile[4]}, 32'h0300);
        checkOutput("swpbSrKept", {28'd0, ifc.sr_flags}, 32'h1);

        $display("[TB] Illegal opcodes");
        snapshot();
        applyStimulus(16'h1200);
        waitIdle();
        checkOutput("illSubop", illegalCount - illBase, 32'd1);
        applyStimulus(16'h0000);
        waitIdle();
        checkOutput("illZero", illegalCount - illBase, 32'd2);
        checkOutput("illNoWrite", rfWeCount - rfBase, 32'd0);
        checkOutput("illSrKept", {28'd0, ifc.sr_flags}, 32'h1);
        checkOutput("illNoIssue", {16'd0, capSrc}, 32'h0003);

        $display("[TB] Reset with ir_valid");
        snapshot();
        @(posedge MCLK);
        #1;
        RST = 1'b1;
        ifc.ir_valid = 1'b1;
        ifc.ir_data  = 16'h0000;
        @(posedge MCLK);
        #1;
        RST = 1'b0;
        ifc.ir_valid = 1'b0;
        @(negedge MCLK);
        checkOutput("rstWordDropped", wordCount - wordBase, 32'd0);
        checkOutput("rstNoDecode", {31'd0, ifc.busy}, 32'd0);
        checkOutput("rstSrRestored", {28'd0, ifc.sr_flags}, {28'd0, TB_RST_SR});

        $display("[TB] Reset during MEM_S wait");
        holdAck = 1'b1;
        snapshot();
        applyStimulus(16'h5725);
        repeat (2) @(negedge MCLK);
        checkOutput("stallMemReq", {31'd0, ifc.mem_req}, 32'd1);
        checkOutput("stallMemAddr", {16'd0, ifc.mem_addr}, 32'h0200);
        RST = 1'b1;
        #1;
        checkOutput("abortReqDrop", {31'd0, ifc.mem_req}, 32'd0);
        @(posedge MCLK);
        #1;
        RST = 1'b0;
        holdAck = 1'b0;
        @(negedge MCLK);
        checkOutput("abortBusy", {31'd0, ifc.busy}, 32'd0);
        checkOutput("abortMemReq", {31'd0, ifc.mem_req}, 32'd0);
        checkOutput("abortSr", {28'd0, ifc.sr_flags}, {28'd0, TB_RST_SR});
        checkOutput("abortNoWrites", (rfWeCount - rfBase) + (memWrCount - memWrBase), 32'd0);
        checkOutput("abortIrReady", {31'd0, ifc.ir_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/alu_exec_sequencer.md
Name: alu_exec_sequencer

Overview:
- Multi-cycle execute sequencer for the 16-bit MSP430-style ALU.
- Accepts instruction and extension words from the fetch stream and decodes Format I, Format II and jump instructions.
- Resolves source and destination addressing modes through a data-memory handshake, issues one ALU operation, then writes back the result and updates the status flags.
- Sits between instruction fetch, the register file, data memory and the ALU.

Parameters:
- RST_SR, 4'b0000, reset value of sr_flags, ordered {V,N,Z,C}.

Ports:
- MCLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- ir_valid  in  1  instruction or extension word available.
- ir_data  in  16  instruction or extension word.
- ir_ready  out  1  word consumed when ir_valid&ir_ready.
- rf_sel_s  out  4  source register index (register file reads combinationally).
- rf_sel_d  out  4  destination register index.
- rf_rdata_s  in  16  source register value.
- rf_rdata_d  in  16  destination register value.
- rf_we  out  1  register write strobe, one cycle.
- rf_waddr  out  4  register write index.
- rf_wdata  out  16  register write data.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write.
- mem_addr  out  16  byte address.
- mem_wdata  out  16  write data.
- mem_ack  in  1  request complete; mem_rdata valid in the same cycle.
- mem_rdata  in  16  read data.
- alu_opcode  out  4  ir[15:12].
- alu_subop  out  3  Format II sub-opcode.
- alu_bw  out  1  byte/word.
- alu_src  out  16  source operand.
- alu_dst  out  16  destination operand.
- alu_start  out  1  one-cycle issue pulse.
- alu_done  in  1  result valid.
- alu_res  in  16  ALU result.
- alu_flags  in  4  {V,N,Z,C} from the ALU.
- sr_flags  out  4  architectural flags.
- jmp_valid  out  1  one-cycle pulse, taken jump.
- jmp_offset  out  16  sign-extended ir[9:0] shifted left 1.
- busy  out  1  high in every state except IDLE.
- illegal  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - sr_flags = RST_SR.
  - All strobes (ir_ready aside) = 0; all buses = 0.
  - ir_ready = 1 in IDLE only.
  - RST mid-operation aborts immediately: mem_req drops and no write occurs.
- Decode on ir[15:12]:
  - 0000 → illegal.
  - 0001 → Format II, fields subop = ir[9:7], BW = ir[6], As = ir[5:4], reg = ir[3:0].
    - Subops 000–011 (RRC, SWPB, RRA, SXT) execute.
    - Subops 100–111 → illegal.
  - 001x → jump, cond = ir[12:10].
  - 0100–1111 → Format I, fields src = ir[11:8], Ad = ir[7], BW = ir[6], As = ir[5:4], dst = ir[3:0].
- Illegal handling: illegal pulses in DECODE, FSM returns to IDLE, nothing else changes.
- Jumps: condition evaluated on sr_flags in DECODE.
  - Conditions: JNE !Z, JEQ Z, JNC !C, JC C, JN N, JGE !(N^V), JL N^V, JMP 1.
  - Taken → jmp_valid pulses in DECODE. Return to IDLE either way.
- States: IDLE, DECODE, EXT_S, MEM_S, EXT_D, MEM_D, ISSUE, WAIT_ALU, WB.
- Source mode (As):
  - 00: register rf_rdata_s.
  - 01: EXT_S takes the next ir word X, then MEM_S reads [X+Rs].
  - 10: MEM_S reads [Rs].
  - 11 with Rs≠R0: MEM_S reads [Rs], then Rs += (BW?1:2) written via rf_we in the MEM_S ack cycle.
  - 11 with Rs=R0: immediate; the EXT_S word is the operand.
- Destination mode (Format I only):
  - Ad = 0: register.
  - Ad = 1: EXT_D takes word Y, then MEM_D reads [Y+Rd].
  - Source extension words are always consumed before destination extension words.
  - In EXT states ir_ready = 1 and the FSM stalls while ir_valid = 0.
- Format II uses the As path for its single operand; both alu_src and alu_dst carry that operand.
- Address arithmetic is mod 2^16, so wrap-around is silent.
- BW = 1: operands masked to [7:0] before issue.
- ISSUE: alu_start pulses once. WAIT_ALU holds until alu_done; the ALU result is captured in the alu_done cycle.
- WB (entered the cycle after alu_done):
  - Flags: sr_flags ← alu_flags, except for MOV (0100) and SWPB.
  - No result write for CMP (1001) or BIT (1011).
  - Otherwise, register destination: rf_we pulses with rf_waddr = dst.
  - Otherwise, memory destination: mem_we write to the MEM_D address, waiting for mem_ack.
  - Then IDLE.
- Back-to-back instructions:
  - ir_ready in IDLE consumes an instruction.
  - Minimum register-to-register latency: 1 accept + DECODE + ISSUE + WAIT_ALU(≥1) + WB = 5 cycles.
- Simultaneous ir_valid with RST: reset wins and the word is not consumed.

Test Plan:
- ADD R4,R5 (0x5405), R4=0x0003, R5=0x0004, ALU returns 0x0007 with flags 0000 → alu_src=3, alu_dst=4; rf_we with waddr=5, wdata=7; sr_flags=0000.
- MOV #0x1234,R6 (0x4036, ext 0x1234) → two ir words consumed; alu_src=0x1234; R6 written; sr_flags unchanged.
- CMP.B @R7+,R8 (0x9778), R7=0x0200, mem[0x0200]=0x01FF → operand 0x00FF; R7→0x0201; flags updated; no R8 write.
- ADD R4,2(R9) with R9=0xFFFF → memory read at 0x0001 (wrap); result written back to 0x0001 with mem_we=1.
- JEQ with Z=1 and ir=0x2401 → jmp_valid pulses, jmp_offset=0x0002; with Z=0, no pulse.
- Opcode 0x0000, then RST asserted during MEM_S wait → illegal pulses; after RST, mem_req=0, busy=0, sr_flags=RST_SR.
